// File: rtl/peribus_timer.sv
// peribus_timer: 16-bit prescaled timer/counter peripheral on the Peribus.
//
// Registers are selected by a 3-bit local offset:
//   0 CTRL     : bit0 en, bit1 oneshot, bit2 irq_en, bit3 reload (write-1 strobe, reads 0)
//   1 PRESCALE : a tick every PRESCALE+1 enabled clocks
//   2 COUNT    : current count
//   3 COMPARE  : terminal count value
//   4 STATUS   : bit0 match, bit1 overrun (both write-1-to-clear)
//   5-7        : read 0, writes ignored
//
// Ports:
//   clk          - clock, all state updates on posedge
//   reset        - asynchronous active-high reset
//   addr         - local register offset
//   write_data   - register write value
//   write_enable - write strobe, sampled at posedge
//   read_enable  - read strobe; read_data is 0 when low
//   read_data    - combinational read of the current registers
//   irq          - level interrupt, match & irq_en

module peribus_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_enable,
    input  logic             read_enable,
    output logic [WIDTH-1:0] read_data,
    output logic             irq
);

    localparam logic [2:0] AddrCtrl     = 3'd0;
    localparam logic [2:0] AddrPrescale = 3'd1;
    localparam logic [2:0] AddrCount    = 3'd2;
    localparam logic [2:0] AddrCompare  = 3'd3;
    localparam logic [2:0] AddrStatus   = 3'd4;

    logic             en;
    logic             oneshot;
    logic             irq_en;
    logic [WIDTH-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] compare;
    logic             match;
    logic             overrun;
    logic [WIDTH-1:0] pcnt;

    logic wr_ctrl;
    logic wr_prescale;
    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic reload;
    logic tick;
    logic hit;

    always_comb begin
        wr_ctrl     = write_enable && (addr == AddrCtrl);
        wr_prescale = write_enable && (addr == AddrPrescale);
        wr_count    = write_enable && (addr == AddrCount);
        wr_compare  = write_enable && (addr == AddrCompare);
        wr_status   = write_enable && (addr == AddrStatus);
        reload      = wr_ctrl && write_data[3];
        tick        = en && (pcnt == prescale);
        // A software COUNT write or a reload in the same cycle suppresses match evaluation.
        hit         = tick && (count == compare) && !wr_count && !reload;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en       <= 1'b0;
            oneshot  <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
            count    <= '0;
            compare  <= '0;
            match    <= 1'b0;
            overrun  <= 1'b0;
            pcnt     <= '0;
        end else begin
            // Prescaler restarts on enable rising, reload or a new divider.
            if ((wr_ctrl && write_data[0] && !en) || reload || wr_prescale) begin
                pcnt <= '0;
            end else if (en) begin
                pcnt <= tick ? '0 : pcnt + 1'b1;
            end

            if (reload) begin
                count <= '0;
            end else if (wr_count) begin
                count <= write_data;
            end else if (tick) begin
                count <= (count == compare) ? '0 : count + 1'b1;
            end

            // A CTRL write takes priority over the one-shot auto-disable.
            if (wr_ctrl) begin
                en      <= write_data[0];
                oneshot <= write_data[1];
                irq_en  <= write_data[2];
            end else if (hit && oneshot) begin
                en <= 1'b0;
            end

            if (wr_prescale) begin
                prescale <= write_data;
            end
            if (wr_compare) begin
                compare <= write_data;
            end

            // Hardware set wins over a simultaneous write-1-to-clear.
            if (hit) begin
                match <= 1'b1;
            end else if (wr_status && write_data[0]) begin
                match <= 1'b0;
            end

            if (hit && match) begin
                overrun <= 1'b1;
            end else if (wr_status && write_data[1]) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (read_enable) begin
            case (addr)
                AddrCtrl:     read_data = {{(WIDTH-3){1'b0}}, irq_en, oneshot, en};
                AddrPrescale: read_data = prescale;
                AddrCount:    read_data = count;
                AddrCompare:  read_data = compare;
                AddrStatus:   read_data = {{(WIDTH-2){1'b0}}, overrun, match};
                default:      read_data = '0;
            endcase
        end
    end

    assign irq = match & irq_en;

endmodule

// File: tb/tb_peribus_timer.sv
// Scoreboard bench for peribus_timer: each bus cycle pushes the expected irq level and
// (for reads) read value from a behavioural model; a monitor pops and compares at negedge.

module tb_peribus_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  addr = '0;
    logic [15:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [15:0] read_data;
    logic        irq;

    peribus_timer #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [15:0] data;
        logic        irq;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   running = 1'b1;

    // Reference model state
    bit m_en, m_oneshot, m_irqen, m_match, m_ovr;
    int m_pre, m_cnt, m_cmp, m_pcnt;

    task automatic model_reset();
        m_en = 0; m_oneshot = 0; m_irqen = 0; m_match = 0; m_ovr = 0;
        m_pre = 0; m_cnt = 0; m_cmp = 0; m_pcnt = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {13'd0, m_irqen, m_oneshot, m_en};
            3'd1:    return m_pre[15:0];
            3'd2:    return m_cnt[15:0];
            3'd3:    return m_cmp[15:0];
            3'd4:    return {14'd0, m_ovr, m_match};
            default: return 16'd0;
        endcase
    endfunction

    // One clock edge of timer behaviour: hardware effects first, software writes override.
    task automatic m_step(input bit we, input logic [2:0] a, input logic [15:0] wd);
        bit tick, hit, ctrl_wr, old_match;
        int cnt, pc;
        if (reset) begin
            model_reset();
            return;
        end
        cnt = m_cnt;
        pc = m_pcnt;
        hit = 0;
        old_match = m_match;
        tick = m_en && (m_pcnt == m_pre);
        if (m_en) pc = tick ? 0 : pc + 1;
        if (tick) begin
            if (m_cnt == m_cmp) begin
                hit = 1;
                cnt = 0;
            end else begin
                cnt = (m_cnt + 1) % 65536;
            end
        end
        ctrl_wr = we && (a == 3'd0);
        if (we) begin
            case (a)
                3'd0: begin
                    if (wd[3]) begin cnt = 0; pc = 0; hit = 0; end
                    if (wd[0] && !m_en) pc = 0;
                end
                3'd1: begin m_pre = int'(wd); pc = 0; end
                3'd2: begin cnt = int'(wd); hit = 0; end
                3'd3: m_cmp = int'(wd);
                3'd4: begin
                    if (wd[0]) m_match = 0;
                    if (wd[1]) m_ovr = 0;
                end
                default: ;
            endcase
        end
        if (hit) begin
            if (old_match) m_ovr = 1;
            m_match = 1;
            if (m_oneshot && !ctrl_wr) m_en = 0;
        end
        if (ctrl_wr) begin
            m_en = wd[0];
            m_oneshot = wd[1];
            m_irqen = wd[2];
        end
        m_cnt = cnt;
        m_pcnt = pc;
    endtask

    // Drive one bus cycle, queue its expectation, advance the model at the edge.
    task automatic cyc(input bit we, input bit re, input logic [2:0] a, input logic [15:0] wd,
                       input string nm);
        exp_t e;
        write_enable = we;
        read_enable = re;
        addr = a;
        write_data = wd;
        e.rd = re;
        e.data = re ? m_read(a) : 16'd0;
        e.irq = m_irqen & m_match;
        e.name = nm;
        q.push_back(e);
        @(posedge clk);
        m_step(we, a, wd);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] wd);
        cyc(1'b1, 1'b0, a, wd, "write");
    endtask

    task automatic rd(input logic [2:0] a, input string nm);
        cyc(1'b0, 1'b1, a, 16'd0, nm);
    endtask

    task automatic clear_all();
        wr(3'd0, 16'h0);
        wr(3'd4, 16'h3);
        wr(3'd2, 16'h0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        while (running) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (irq !== e.irq) begin
                    bad++;
                    $display("FAIL irq(%s) got=%0b want=%0b t=%0t", e.name, irq, e.irq, $time);
                end
                if (e.rd) begin
                    total++;
                    if (read_data !== e.data) begin
                        bad++;
                        $display("FAIL read %s addr=%0d got=%h want=%h t=%0t",
                                 e.name, addr, read_data, e.data, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0]  ra;
        logic [15:0] rwd;
        int          op;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset-state reads
        for (int i = 0; i < 8; i++) rd(3'(i), "reset_state");

        // Periodic: PRESCALE=0, COMPARE=3, CTRL=0x5, match/overrun without clearing
        wr(3'd1, 16'd0);
        wr(3'd3, 16'd3);
        wr(3'd0, 16'h5);
        for (int i = 0; i < 10; i++) rd(3'd2, "periodic_count");
        rd(3'd4, "periodic_status");
        clear_all();

        // One-shot: PRESCALE=2, COMPARE=1, CTRL=0x3
        wr(3'd1, 16'd2);
        wr(3'd3, 16'd1);
        wr(3'd0, 16'h3);
        for (int i = 0; i < 8; i++) rd(3'd2, "oneshot_count");
        rd(3'd0, "oneshot_ctrl");
        rd(3'd4, "oneshot_status");
        clear_all();

        // Wrap: COUNT=0xFFFF, COMPARE=0x10, PRESCALE=0
        wr(3'd1, 16'd0);
        wr(3'd3, 16'h0010);
        wr(3'd2, 16'hFFFF);
        wr(3'd0, 16'h1);
        rd(3'd2, "wrap_count");
        for (int i = 0; i < 18; i++) rd(3'd4, "wrap_status");
        clear_all();

        // Set wins over W1C at the match edge
        wr(3'd3, 16'd3);
        wr(3'd0, 16'h5);
        cyc(1'b0, 1'b0, 3'd0, 16'd0, "idle");
        cyc(1'b0, 1'b0, 3'd0, 16'd0, "idle");
        cyc(1'b0, 1'b0, 3'd0, 16'd0, "idle");
        wr(3'd4, 16'h1);
        rd(3'd4, "set_wins");
        wr(3'd4, 16'h1);
        rd(3'd4, "w1c");
        wr(3'd4, 16'h0);
        rd(3'd4, "w0_noop");

        // COUNT write against a tick, then reload, then unused offsets
        wr(3'd2, 16'h0007);
        rd(3'd2, "count_write_wins");
        wr(3'd0, 16'hD);
        rd(3'd0, "reload_ctrl");
        cyc(1'b1, 1'b1, 3'd3, 16'h1234, "rw_same_cycle");
        rd(3'd3, "rw_after");
        wr(3'd5, 16'hFFFF);
        for (int i = 5; i < 8; i++) rd(3'(i), "unused");

        // Reset during counting
        wr(3'd2, 16'd5);
        wr(3'd0, 16'h1);
        cyc(1'b0, 1'b0, 3'd0, 16'd0, "idle");
        reset = 1'b1;
        model_reset();
        rd(3'd2, "in_reset_count");
        rd(3'd0, "in_reset_ctrl");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), "after_reset");
        for (int i = 0; i < 3; i++) rd(3'd2, "stopped");

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            op = int'($urandom_range(0, 9));
            ra = 3'($urandom_range(0, 7));
            case (ra)
                3'd0: rwd = 16'($urandom_range(0, 15));
                3'd1: rwd = 16'($urandom_range(0, 3));
                3'd2: rwd = $urandom_range(0, 1) ? 16'($urandom_range(0, 6))
                                                 : 16'($urandom_range(16'hFFF8, 16'hFFFF));
                3'd3: rwd = 16'($urandom_range(0, 7));
                3'd4: rwd = 16'($urandom_range(0, 3));
                default: rwd = 16'($urandom);
            endcase
            if (op < 4) rd(ra, "rand_read");
            else if (op < 6) wr(ra, rwd);
            else if (op == 6) cyc(1'b1, 1'b1, ra, rwd, "rand_rw");
            else cyc(1'b0, 1'b0, 3'd0, 16'd0, "idle");
        end

        write_enable = 1'b0;
        read_enable = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
